// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accum_pkg
// Brief    : Shared layer enum and width/saturation helpers for the accumulate stage.
// Revision : 1.0 - initial release
// ============================================================================
package accum_pkg;

    typedef enum logic {
        LAYER_CONV = 1'b0,
        LAYER_FC   = 1'b1
    } layer_e;

    // Counter width that stays legal for a count of one.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width that holds an exact sum of num operands, each up to max(psum_w, acc_w) bits.
    function automatic int tree_width(input int psum_w, input int acc_w, input int num);
        int base;
        base = (psum_w > acc_w) ? psum_w : acc_w;
        return base + ((num <= 1) ? 0 : $clog2(num));
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_adder_tree.sv
`default_nettype none
// ============================================================================
// Module   : psum_adder_tree
// Brief    : Combinational binary reduction of signed partial sums, saturated to ACC_W.
// Revision : 1.0 - initial release
// ============================================================================
module psum_adder_tree
    import accum_pkg::*;
#(
    parameter int NUM_PSUM = 9,
    parameter int PSUM_W   = 18,
    parameter int ACC_W    = 33
) (
    input  logic signed [PSUM_W-1:0] psum [NUM_PSUM],
    output logic signed [ACC_W-1:0]  tree_sum
);

    localparam int LEVELS = (NUM_PSUM <= 1) ? 0 : $clog2(NUM_PSUM);
    localparam int LEAVES = 1 << LEVELS;
    localparam int TREE_W = tree_width(PSUM_W, ACC_W, NUM_PSUM);

    // Heap layout: node n has children 2n+1 and 2n+2, leaves occupy the tail.
    logic signed [TREE_W-1:0] w_node [2*LEAVES-1];

    generate
        for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
            if (i < NUM_PSUM) begin : g_real
                assign w_node[LEAVES-1+i] = TREE_W'(psum[i]);
            end else begin : g_pad
                assign w_node[LEAVES-1+i] = '0;
            end
        end
        for (genvar n = 0; n < LEAVES - 1; n++) begin : g_node
            assign w_node[n] = w_node[2*n+1] + w_node[2*n+2];
        end
    endgenerate

    assign tree_sum = ACC_W'(sat_signed(64'(w_node[0]), ACC_W));

endmodule
`default_nettype wire

// File: rtl/accumulate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : accumulate_pipe
// Brief    : Two-stage psum reduce + bias/accumulate with saturation, optional ReLU
//            and a valid/ready handshake; conv (per beat) and fc (per neuron) modes.
// Revision : 1.0 - initial release
// ============================================================================
module accumulate_pipe
    import accum_pkg::*;
#(
    parameter int NUM_PSUM   = 9,
    parameter int PSUM_W     = 18,
    parameter int BIAS_W     = 32,
    parameter int FC_BEATS   = 16,
    parameter int FC_NEURONS = 64,
    parameter int RELU_EN    = 0
) (
    input  logic                     clk_i,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     layer,
    input  logic signed [PSUM_W-1:0] psum [NUM_PSUM],
    input  logic signed [BIAS_W-1:0] bias,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [BIAS_W-1:0] sum,
    output logic                     conv_comp,
    output logic                     fc_line_done,
    output logic                     fc_done
);

    localparam int ACC_W  = BIAS_W + 1;
    localparam int BEAT_W = cnt_width(FC_BEATS);
    localparam int NEUR_W = cnt_width(FC_NEURONS);
    localparam logic [BEAT_W-1:0] c_beat_last = BEAT_W'(FC_BEATS - 1);
    localparam logic [NEUR_W-1:0] c_neur_last = NEUR_W'(FC_NEURONS - 1);

    logic                     r_s1_valid;
    layer_e                   r_s1_layer;
    logic signed [BIAS_W-1:0] r_s1_bias;
    logic signed [ACC_W-1:0]  r_s1_tree;

    logic signed [ACC_W-1:0]  r_acc;
    logic [BEAT_W-1:0]        r_beat_cnt;
    logic [NEUR_W-1:0]        r_neur_cnt;

    logic                     r_out_valid;
    logic signed [BIAS_W-1:0] r_sum;
    logic                     r_conv_comp;
    logic                     r_fc_line_done;
    logic                     r_fc_done;

    logic                     w_adv;
    logic signed [ACC_W-1:0]  w_tree;
    logic                     w_fc;
    logic                     w_beat_last;
    logic                     w_neur_last;
    logic                     w_emit;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [ACC_W-1:0]  w_acc_next;
    logic signed [BIAS_W-1:0] w_result;
    logic signed [BIAS_W-1:0] w_out;

    psum_adder_tree #(
        .NUM_PSUM (NUM_PSUM),
        .PSUM_W   (PSUM_W),
        .ACC_W    (ACC_W)
    ) u_tree (
        .psum     (psum),
        .tree_sum (w_tree)
    );

    // A single advance enable freezes both stages together under back-pressure.
    assign w_adv    = (!r_out_valid || out_ready) && !rst;
    assign in_ready = w_adv;

    // A neuron in progress forces fc handling regardless of the incoming layer bit.
    assign w_fc        = (r_s1_layer == LAYER_FC) || (r_beat_cnt != '0);
    assign w_beat_last = (r_beat_cnt == c_beat_last);
    assign w_neur_last = (r_neur_cnt == c_neur_last);
    assign w_emit      = !w_fc || w_beat_last;
    assign w_base      = (r_beat_cnt != '0) ? r_acc : ACC_W'(r_s1_bias);
    assign w_acc_next  = ACC_W'(sat_signed(64'(w_base) + 64'(r_s1_tree), ACC_W));
    assign w_result    = BIAS_W'(sat_signed(64'(w_acc_next), BIAS_W));
    assign w_out       = ((RELU_EN != 0) && (w_result < 0)) ? '0 : w_result;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_layer <= LAYER_CONV;
            r_s1_bias  <= '0;
            r_s1_tree  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_layer <= layer_e'(layer);
                r_s1_bias  <= bias;
                r_s1_tree  <= w_tree;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_acc          <= '0;
            r_beat_cnt     <= '0;
            r_neur_cnt     <= '0;
            r_out_valid    <= 1'b0;
            r_sum          <= '0;
            r_conv_comp    <= 1'b0;
            r_fc_line_done <= 1'b0;
            r_fc_done      <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid && w_emit;
            if (r_s1_valid) begin
                r_acc <= w_acc_next;
                if (w_fc) begin
                    r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + 1'b1;
                    if (w_beat_last) begin
                        r_neur_cnt <= w_neur_last ? '0 : r_neur_cnt + 1'b1;
                    end
                end
                if (w_emit) begin
                    r_sum          <= w_out;
                    r_conv_comp    <= !w_fc;
                    r_fc_line_done <= w_fc;
                    r_fc_done      <= w_fc && w_neur_last;
                end
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign sum          = r_sum;
    assign conv_comp    = r_conv_comp;
    assign fc_line_done = r_fc_line_done;
    assign fc_done      = r_fc_done;

endmodule
`default_nettype wire

// File: tb/tb_accumulate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_accumulate_pipe
// Brief    : Scoreboard bench for accumulate_pipe (plain and ReLU instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulate_pipe;

    localparam int NUM_PSUM   = 9;
    localparam int PSUM_W     = 18;
    localparam int BIAS_W     = 16;
    localparam int ACC_W      = BIAS_W + 1;
    localparam int FC_BEATS   = 4;
    localparam int FC_NEURONS = 2;

    typedef struct {
        longint val;
        bit     conv;
        bit     line;
        bit     done;
        bit     chk_lat;
        int     acc_cyc;
    } exp_t;

    logic                     clk_i = 1'b0;
    logic                     rst   = 1'b1;
    logic                     in_valid = 1'b0;
    logic                     layer = 1'b0;
    logic signed [PSUM_W-1:0] psum [NUM_PSUM];
    logic signed [BIAS_W-1:0] bias = '0;
    logic                     out_ready = 1'b1;

    logic                     in_ready, out_valid, conv_comp, fc_line_done, fc_done;
    logic signed [BIAS_W-1:0] sum;
    logic                     in_ready_r, out_valid_r, conv_comp_r, fc_line_done_r, fc_done_r;
    logic signed [BIAS_W-1:0] sum_r;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_err    = 0;
    int     cyc      = 0;
    int     bp_mode  = 0;
    int     stall_seen = 0;
    longint m_acc    = 0;
    int     m_beat   = 0;
    int     m_neur   = 0;

    accumulate_pipe #(
        .NUM_PSUM(NUM_PSUM), .PSUM_W(PSUM_W), .BIAS_W(BIAS_W),
        .FC_BEATS(FC_BEATS), .FC_NEURONS(FC_NEURONS), .RELU_EN(0)
    ) dut (
        .clk_i(clk_i), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .layer(layer), .psum(psum), .bias(bias), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .conv_comp(conv_comp),
        .fc_line_done(fc_line_done), .fc_done(fc_done)
    );

    accumulate_pipe #(
        .NUM_PSUM(NUM_PSUM), .PSUM_W(PSUM_W), .BIAS_W(BIAS_W),
        .FC_BEATS(FC_BEATS), .FC_NEURONS(FC_NEURONS), .RELU_EN(1)
    ) dut_relu (
        .clk_i(clk_i), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .layer(layer), .psum(psum), .bias(bias), .out_valid(out_valid_r),
        .out_ready(out_ready), .sum(sum_r), .conv_comp(conv_comp_r),
        .fc_line_done(fc_line_done_r), .fc_done(fc_done_r)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint sat(input longint v, input int w);
        longint hi;
        hi = (64'sd1 <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    // Reference behaviour: plain integer arithmetic over the current psum/bias inputs.
    task automatic model_beat(input logic lay, input int acc_cyc);
        longint tree;
        exp_t   e;
        bit     fc;
        tree = 0;
        for (int i = 0; i < NUM_PSUM; i++) tree += longint'(psum[i]);
        tree = sat(tree, ACC_W);
        fc = lay || (m_beat != 0);
        e.conv = 0; e.line = 0; e.done = 0;
        e.chk_lat = (bp_mode == 0);
        e.acc_cyc = acc_cyc;
        if (!fc) begin
            m_acc  = sat(longint'(bias) + tree, ACC_W);
            e.val  = sat(m_acc, BIAS_W);
            e.conv = 1;
            q.push_back(e);
        end else begin
            m_acc  = sat(((m_beat == 0) ? longint'(bias) : m_acc) + tree, ACC_W);
            m_beat = m_beat + 1;
            if (m_beat == FC_BEATS) begin
                m_beat = 0;
                m_neur = m_neur + 1;
                e.val  = sat(m_acc, BIAS_W);
                e.line = 1;
                e.done = (m_neur == FC_NEURONS);
                if (e.done) m_neur = 0;
                q.push_back(e);
            end
        end
    endtask

    task automatic fill_ps(input longint v);
        for (int i = 0; i < NUM_PSUM; i++) psum[i] = PSUM_W'(v);
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic send(input logic lay, input logic signed [BIAS_W-1:0] b);
        bit accepted;
        int waited;
        accepted = 0;
        waited   = 0;
        in_valid = 1'b1;
        layer    = lay;
        bias     = b;
        while (!accepted) begin
            #1;
            if (in_ready) begin
                accepted = 1;
                model_beat(lay, cyc);
            end
            @(negedge clk_i);
            if (!accepted) begin
                waited++;
                if (waited > 500) begin
                    $display("FAIL send_timeout: got %0d waited cycles, required < 500", waited);
                    $fatal(1);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 300) begin
            @(negedge clk_i);
            w++;
        end
        check(q.size() == 0, "drain_timeout", q.size(), 0);
        @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        if (bp_mode == 0)      out_ready = 1'b1;
        else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
        else                   out_ready = 1'b0;
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin : monitor
        bit     prev_hold;
        longint prev_sum;
        exp_t   e;
        prev_hold = 0;
        prev_sum  = 0;
        forever begin
            @(negedge clk_i);
            #2;
            if (rst) begin
                prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    check(out_valid == 1'b1, "hold_valid", out_valid, 1);
                    check(longint'(sum) == prev_sum, "hold_sum", sum, prev_sum);
                end
                if (out_valid && !out_ready) begin
                    stall_seen++;
                    check(in_ready == 1'b0, "stall_in_ready", in_ready, 0);
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        check(0, "unexpected_output", sum, 0);
                    end else begin
                        e = q.pop_front();
                        check(longint'(sum) == e.val, "sum", sum, e.val);
                        check(conv_comp == e.conv, "conv_comp", conv_comp, e.conv);
                        check(fc_line_done == e.line, "fc_line_done", fc_line_done, e.line);
                        check(fc_done == e.done, "fc_done", fc_done, e.done);
                        check(out_valid_r == 1'b1, "relu_valid", out_valid_r, 1);
                        check(longint'(sum_r) == ((e.val < 0) ? 0 : e.val), "relu_sum",
                              sum_r, (e.val < 0) ? 0 : e.val);
                        if (e.chk_lat)
                            check((cyc - e.acc_cyc) == 2, "latency", cyc - e.acc_cyc, 2);
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_sum  = sum;
            end
        end
    end

    initial begin : stimulus
        fill_ps(0);
        repeat (3) @(negedge clk_i);
        #1;
        check(out_valid == 0, "reset_out_valid", out_valid, 0);
        check(sum == 0, "reset_sum", sum, 0);
        check({conv_comp, fc_line_done, fc_done} == 3'b000, "reset_flags",
              {conv_comp, fc_line_done, fc_done}, 0);
        @(negedge clk_i);
        rst = 1'b0;
        #1;
        check(in_ready == 1'b1, "in_ready_after_reset", in_ready, 1);
        @(negedge clk_i);

        // Conv: 9 x 1 + 5 = 14, eight back-to-back beats
        fill_ps(1);
        for (int i = 0; i < 8; i++) send(1'b0, 16'sd5);
        drain();

        // Fc: 4 beats of 9 x 2 on bias -10 gives 62, two neurons per layer
        fill_ps(2);
        for (int i = 0; i < 8; i++) send(1'b1, -16'sd10);
        drain();

        // Saturation both ways
        fill_ps(65536);
        send(1'b0, 16'sd32767);
        fill_ps(-65536);
        send(1'b0, -16'sd32768);
        drain();

        // Back-pressure: output frozen for several cycles while beats keep arriving
        bp_mode = 2;
        fill_ps(7);
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(1'b0, 16'(i * 100 - 200));
            end
            begin
                repeat (8) @(negedge clk_i);
                bp_mode = 0;
            end
        join
        drain();
        check(stall_seen >= 5, "backpressure_stall_cycles", stall_seen, 5);

        // Mode lock: fc beat then layer=0 beats stay fc; later conv beats are conv
        fill_ps(3);
        send(1'b1, 16'sd100);
        for (int i = 0; i < 3; i++) send(1'b0, 16'sd7);
        send(1'b0, 16'sd7);
        send(1'b0, -16'sd50);
        drain();

        // Reset in the middle of a neuron discards the partial state
        fill_ps(5);
        send(1'b1, 16'sd1000);
        send(1'b1, 16'sd1000);
        repeat (2) @(negedge clk_i);
        rst = 1'b1;
        #1;
        check(out_valid == 0 && sum == 0, "midreset_outputs", sum, 0);
        @(negedge clk_i);
        rst = 1'b0;
        m_acc = 0; m_beat = 0; m_neur = 0;
        q.delete();
        @(negedge clk_i);
        fill_ps(1);
        for (int i = 0; i < 4; i++) send(1'b1, -16'sd3);
        drain();

        // Randomized traffic with random back-pressure
        bp_mode = 1;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_PSUM; i++) begin
                if ($urandom_range(0, 1) != 0) psum[i] = PSUM_W'($urandom);
                else psum[i] = PSUM_W'(int'($urandom_range(0, 2000)) - 1000);
            end
            send(1'($urandom_range(0, 1)), BIAS_W'($urandom));
            if ($urandom_range(0, 4) == 0) @(negedge clk_i);
        end
        bp_mode = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
